debounce_sync: RTL

- Input conditioning stage directly upstream of the one-cycle pulse detector.
- Takes a raw asynchronous level (button, strap, external line) and brings it into the `clk` domain through a 2-flop synchronizer.
- Rejects glitches shorter than a programmable stability window.
- Delivers a clean level plus registered one-cycle rise/fall strobes; `a_clean` feeds the detector's `a` input directly.
- Counts rejected glitches for debug.

---
 rtl/debounce_sync.sv | 96 +++++++++
 1 files changed

// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchronizer followed by a stability-window debouncer.
// Produces a clean level, registered one-cycle rise/fall strobes and a
// saturating count of rejected glitches.
module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_raw,
    output logic                a_clean,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned          CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [GLITCH_W-1:0]  GL_ONE   = GLITCH_W'(1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_clean;
    logic                r_rise;
    logic                r_fall;
    logic [CNT_W-1:0]    r_cnt;
    logic [GLITCH_W-1:0] r_glitch;

    logic                w_s;
    logic                w_clean_nxt;
    logic                w_rise_nxt;
    logic                w_fall_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [GLITCH_W-1:0] w_glitch_nxt;

    // Two-flop synchronizer; only r_sync1 may go metastable, nothing sits between the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= a_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    // Next-state: glitch reject, idle, commit, or keep counting the excursion.
    always_comb begin
        w_clean_nxt  = r_clean;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_glitch_nxt = r_glitch;
        if (w_s == r_clean) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = '0;
                if (!(&r_glitch)) begin
                    w_glitch_nxt = r_glitch + GL_ONE;
                end
            end
        end else if (r_cnt == CNT_LAST) begin
            w_clean_nxt = w_s;
            w_cnt_nxt   = '0;
            w_rise_nxt  = w_s;
            w_fall_nxt  = ~w_s;
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // Debouncer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clean  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
            r_glitch <= '0;
        end else begin
            r_clean  <= w_clean_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_cnt    <= w_cnt_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    assign a_clean    = r_clean;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign glitch_cnt = r_glitch;

endmodule
